// File: rtl/input_fifo_rx_if.sv
// Link bundle between the upstream RTS/DCTS arbiter, the local output arbiters and input_fifo_rx.
interface input_fifo_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] RX;
    logic                  DRTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic                  CTS;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;

    // Upstream router plus local arbiters drive the requests and consume the head flit.
    modport master (
        output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full
    );

    modport slave (
        input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full
    );
endinterface

// File: rtl/input_fifo_rx.sv
// Router input-port FIFO: RTS/DCTS receiver with first-word-fall-through head for five arbiters.
// Optional sticky error flags are built when INPUT_FIFO_ERR_EN is defined.
module input_fifo_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input_fifo_rx_if.slave        bus
`ifdef INPUT_FIFO_ERR_EN
    ,
    output logic                  err_read_empty,
    output logic                  err_multi_read,
    output logic                  err_cts_full
`endif
);
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE    = (PTR_W)'(1);
    localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic                  cts_ff_r;
    logic [PTR_W-1:0]      write_ptr_r;
    logic [PTR_W-1:0]      read_ptr_r;
    logic [PTR_W:0]        count_r;
    logic [PTR_W:0]        count_next_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [4:0]            rd_lines_s;
    logic                  rd_req_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  cts_in_s;
    logic                  empty_s;
    logic                  full_s;

    assign rd_lines_s = {bus.read_en_N, bus.read_en_E, bus.read_en_W, bus.read_en_S, bus.read_en_L};
    assign rd_req_s   = |rd_lines_s;
    assign empty_s    = (count_r == {(PTR_W+1){1'b0}});
    assign full_s     = (count_r == FULL_COUNT);
    assign rd_s       = rd_req_s & ~empty_s;
    // Full is judged at CTS issue; the only write that can follow is the one this CTS grants.
    assign cts_in_s   = bus.DRTS & ~cts_ff_r & ~full_s;
    assign wr_s       = cts_ff_r & bus.DRTS;

    assign bus.CTS      = cts_ff_r;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
    assign bus.Data_out = mem_r[read_ptr_r];

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Clear-to-send pulse register; self-clearing because CTS_in masks on its own output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_ff_r <= 1'b0;
        end else begin
            cts_ff_r <= cts_in_s;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_ptr_r <= {PTR_W{1'b0}};
            read_ptr_r  <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_s) begin
                write_ptr_r <= write_ptr_r + PTR_ONE;
            end
            if (rd_s) begin
                read_ptr_r <= read_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Flit storage; never cleared, contents past the pointers are simply stale.
    always_ff @(posedge clk) begin
        if (!rst && wr_s) begin
            mem_r[write_ptr_r] <= bus.RX;
        end
    end

`ifdef INPUT_FIFO_ERR_EN
    function automatic logic multi_hot(input logic [4:0] v);
        multi_hot = |(v & (v - 5'd1));
    endfunction

    // Sticky diagnostics; observation only, they never alter datapath behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_read_empty <= 1'b0;
            err_multi_read <= 1'b0;
            err_cts_full   <= 1'b0;
        end else begin
            err_read_empty <= err_read_empty | (rd_req_s & empty_s);
            err_multi_read <= err_multi_read | multi_hot(rd_lines_s);
            err_cts_full   <= err_cts_full | (cts_in_s & full_s);
        end
    end
`endif
endmodule

// File: tb/tb_input_fifo_rx.sv
// Directed bench for input_fifo_rx with a queue scoreboard of stored flits.
module tb_input_fifo_rx;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    input_fifo_rx_if #(.DATA_WIDTH(32)) bus ();

`ifdef INPUT_FIFO_ERR_EN
    logic err_read_empty;
    logic err_multi_read;
    logic err_cts_full;
`endif

    input_fifo_rx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef INPUT_FIFO_ERR_EN
        ,
        .err_read_empty (err_read_empty),
        .err_multi_read (err_multi_read),
        .err_cts_full   (err_cts_full)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int line, input logic v);
        case (line)
            0:       bus.read_en_N = v;
            1:       bus.read_en_E = v;
            2:       bus.read_en_W = v;
            3:       bus.read_en_S = v;
            4:       bus.read_en_L = v;
            default: ;
        endcase
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_empty"}, {31'd0, bus.empty}, {31'd0, sb.size() == 0});
        chk({tag, "_full"},  {31'd0, bus.full},  {31'd0, sb.size() == 4});
        if (sb.size() > 0) chk({tag, "_head"}, bus.Data_out, sb[0]);
    endtask

    task automatic wait_cts(input int budget, output int waited);
        waited = 0;
        while (bus.CTS !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
        chk("cts_seen", {31'd0, bus.CTS}, 32'd1);
    endtask

    // Full handshake; pop_line >= 0 also pops on the write edge.
    task automatic send(input logic [31:0] d, input int pop_line);
        int  w;
        bit  popped;
        popped = 1'b0;
        bus.RX   = d;
        bus.DRTS = 1'b1;
        wait_cts(4, w);
        chk("cts_latency", w, 32'd1);
        if (pop_line >= 0) begin
            if (sb.size() > 0) popped = 1'b1;
            set_rd(pop_line, 1'b1);
        end
        step();
        set_rd(pop_line, 1'b0);
        if (popped) void'(sb.pop_front());
        sb.push_back(d);
        chk("cts_one_cycle", {31'd0, bus.CTS}, 32'd0);
        bus.DRTS = 1'b0;
        bus.RX   = 32'hDEAD_BEEF;
        check_flags("after_write");
        step();
    endtask

    task automatic pop(input int line);
        chk("pop_not_empty", {31'd0, bus.empty}, 32'd0);
        if (sb.size() > 0) chk("pop_data", bus.Data_out, sb[0]);
        set_rd(line, 1'b1);
        step();
        set_rd(line, 1'b0);
        if (sb.size() > 0) void'(sb.pop_front());
        check_flags("after_pop");
    endtask

    initial begin
        int w;
        rst = 1'b1;
        bus.RX = 32'd0;
        bus.DRTS = 1'b0;
        bus.read_en_N = 1'b0;
        bus.read_en_E = 1'b0;
        bus.read_en_W = 1'b0;
        bus.read_en_S = 1'b0;
        bus.read_en_L = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 10; i++) begin
            chk("idle_cts", {31'd0, bus.CTS}, 32'd0);
            check_flags("idle");
            step();
        end

        // Single transfer, popped by the east arbiter
        send(32'hA5A5_0001, -1);
        pop(1);

        // Fill to full, then a blocked request released by one pop
        for (int i = 1; i <= 4; i++) send(32'(i), -1);
        chk("fill_full", {31'd0, bus.full}, 32'd1);
        bus.RX   = 32'd5;
        bus.DRTS = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("blocked_cts", {31'd0, bus.CTS}, 32'd0);
        end
        pop(0);
        wait_cts(2, w);
        chk("cts_after_pop", {31'd0, w <= 2}, 32'd1);
        step();
        sb.push_back(32'd5);
        chk("cts_one_cycle", {31'd0, bus.CTS}, 32'd0);
        bus.DRTS = 1'b0;
        check_flags("refill");
        step();
        for (int i = 1; i <= 4; i++) pop(i);

        // Wrap-around with single occupancy
        for (int i = 0; i < 10; i++) begin
            send(32'(i), -1);
            chk("wrap_not_full", {31'd0, bus.full}, 32'd0);
            pop(i % 5);
        end

        // Write into empty FIFO while a pop request is ignored
        send(32'h0000_0077, 3);
        pop(2);

        // Simultaneous pop and write near full, order preserved
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), -1);
        chk("sim_full", {31'd0, bus.full}, 32'd1);
        pop(4);
        send(32'h14, 4);
        send(32'h15, 4);
        send(32'h16, -1);
        chk("sim_refull", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 4; i++) pop(i);

        // Reset in the middle of a handshake with two flits stored
        send(32'h21, -1);
        send(32'h22, -1);
        bus.RX   = 32'h23;
        bus.DRTS = 1'b1;
        wait_cts(4, w);
        rst      = 1'b1;
        bus.DRTS = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        chk("rst_cts", {31'd0, bus.CTS}, 32'd0);
        check_flags("rst_mid");
        step();
        chk("rst_cts_hold", {31'd0, bus.CTS}, 32'd0);
        send(32'h31, -1);
        pop(0);

`ifdef INPUT_FIFO_ERR_EN
        chk("err_clear_re", {31'd0, err_read_empty}, 32'd0);
        chk("err_clear_mr", {31'd0, err_multi_read}, 32'd0);
        bus.read_en_N = 1'b1;
        bus.read_en_W = 1'b1;
        step();
        bus.read_en_N = 1'b0;
        bus.read_en_W = 1'b0;
        check_flags("err_empty");
        for (int i = 0; i < 3; i++) begin
            chk("err_read_empty", {31'd0, err_read_empty}, 32'd1);
            chk("err_multi_read", {31'd0, err_multi_read}, 32'd1);
            chk("err_cts_full",   {31'd0, err_cts_full},   32'd0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_rst_re", {31'd0, err_read_empty}, 32'd0);
        chk("err_rst_mr", {31'd0, err_multi_read}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
